ram_dp_pipe: RTL and testbench
==============================

// Module: ram_dp_pipe
// PURPOSE
//   Parametrised simple dual-port RAM. It is the next generation of the team's
//   single-cycle frame/pixel RAM. Adds per-lane write masking, a selectable read
//   latency (1 or 2) with a rd_valid strobe, and write-first same-address forwarding.
//   Sits between pixel/compute producers and display/readback consumers.
// PARAMETERS
//   ADDRESS_WIDTH  20  address bits; depth = 2**ADDRESS_WIDTH words
//   DATA_WIDTH     15  word width in bits; must be divisible by LANES
//   LANES          1   write-mask lanes; lane width LW = DATA_WIDTH/LANES
//   READ_LATENCY   1   cycles from accepted read to valid data; 1 or 2 only
// PORTS
//   clk      in   1              single clock; all logic on posedge
//   rst      in   1              synchronous, active-high reset
//   wr_en    in   1              write request
//   wr_addr  in   ADDRESS_WIDTH  write address
//   wr_mask  in   LANES          per-lane write enable; bit i covers din[i*LW +: LW]
//   din      in   DATA_WIDTH     write data
//   rd_en    in   1              read request
//   rd_addr  in   ADDRESS_WIDTH  read address
//   dout     out  DATA_WIDTH     read data
//   rd_valid out  1              high for exactly one cycle per accepted read
//   busy     out  1              clear in progress; reads and writes are ignored while high
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - dout=0, rd_valid=0, all read-pipeline registers cleared.
//     - Array contents are not reset; only the RAM_CLEAR_EN sequence clears them.
//   - Write accepted when wr_en && !busy.
//     - Each lane with wr_mask[i]=1 is updated; other lanes keep old data.
//     - wr_mask=0 is a no-op.
//   - Read accepted when rd_en && !busy.
//     - READ_LATENCY=1: dout/rd_valid update at the posedge that samples rd_en.
//     - READ_LATENCY=2: one additional output register stage; valid is pipelined alongside data.
//     - One read accepted per cycle. Back-to-back reads yield consecutive rd_valid in request order.
//     - dout holds its last value when rd_valid=0.
//   - Same-cycle write and read to the same address (write-first):
//     - Returned word = din on masked lanes, prior array data on unmasked lanes.
//     - Different addresses are fully independent.
//   - Addresses cover the full 2**ADDRESS_WIDTH range; no wrap or out-of-range case exists.
//   - rst mid-operation:
//     - In-flight reads are discarded; rd_valid=0 from the reset edge onward.
//     - A write on the reset edge is ignored; array contents are otherwise retained.
//   - Illegal READ_LATENCY (not 1 or 2) or DATA_WIDTH % LANES != 0: elaboration-time $error.
// CONFIGURATION
//   - Macro RAM_CLEAR_EN defined: two-state FSM {CLEAR, IDLE}.
//     - rst forces CLEAR with clr_addr=0; busy = (state==CLEAR).
//     - In CLEAR, each cycle writes 0 to clr_addr and increments it.
//     - After writing address 2**ADDRESS_WIDTH-1, the FSM moves to IDLE.
//     - busy is 1 for exactly 2**ADDRESS_WIDTH cycles after rst deasserts.
//     - rst during CLEAR restarts the sweep at 0.
//     - User wr_en/rd_en are ignored while busy; no rd_valid results.
//   - Macro undefined: no FSM; busy tied 0; array power-up contents undefined.
// TESTING  (ADDRESS_WIDTH=4, DATA_WIDTH=16, LANES=2, READ_LATENCY=1 unless noted)
//   1. Write 0xABCD @3, mask 2'b11; next cycle read @3
//      -> dout=0xABCD, rd_valid=1 for one cycle, 1 cycle after rd_en.
//   2. Write 0x1234 @3, mask 2'b01; read @3 -> dout=0xAB34 (upper lane kept).
//   3. Same edge: write 0x5555 @5 (mask 11) and read @5 -> dout=0x5555 (forwarded).
//      Same edge with mask 2'b10 over 0x0000: write 0x5555 @6, read @6 -> dout=0x5500.
//   4. READ_LATENCY=2: reads @0,1,2,3 on 4 consecutive cycles
//      -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first read; data in order.
//   5. rst asserted one cycle after a read is issued with READ_LATENCY=2
//      -> rd_valid stays 0, dout=0; afterwards read @3 -> 0xAB34 (memory retained).
//   6. RAM_CLEAR_EN: release rst -> busy=1 for exactly 16 cycles.
//      A write of 0xFFFF @7 during busy is ignored; reads @0..15 after busy falls all return 0x0000.

Source files
------------

// File: rtl/ram_dp_pipe.sv
// -----------------------------------------------------------------------------
// ram_dp_pipe
//   Simple dual-port RAM (one write port, one read port, single clock) with
//   per-lane write masking, selectable read latency (1 or 2 cycles) with a
//   rd_valid strobe, and write-first forwarding when a read and a write hit
//   the same address on the same edge.
//
//   Optional feature macro: RAM_CLEAR_EN
//     Defined   : after reset a clear sweep writes zero to every word; busy is
//                 high during the sweep and user reads/writes are ignored.
//     Undefined : no sweep, busy tied low, array power-up contents undefined.
//
// Parameters
//   ADDRESS_WIDTH  address bits; depth = 2**ADDRESS_WIDTH words
//   DATA_WIDTH     word width; must be divisible by LANES
//   LANES          number of write-mask lanes, lane width = DATA_WIDTH/LANES
//   READ_LATENCY   1 or 2 cycles from accepted read to rd_valid
//
// Ports
//   clk       in   single clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_mask   in   per-lane write enable, bit i covers din[i*LW +: LW]
//   din       in   write data
//   rd_en     in   read request
//   rd_addr   in   read address
//   dout      out  read data, holds its value while rd_valid is low
//   rd_valid  out  one-cycle strobe per accepted read
//   busy      out  clear sweep in progress; reads and writes ignored
// -----------------------------------------------------------------------------
module ram_dp_pipe #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 15,
    parameter int LANES         = 1,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [LANES-1:0]         wr_mask,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     rd_valid,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int LW    = DATA_WIDTH / LANES;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("ram_dp_pipe: READ_LATENCY must be 1 or 2");
    end

    if ((DATA_WIDTH % LANES) != 0) begin : g_bad_lanes
        $error("ram_dp_pipe: DATA_WIDTH must be divisible by LANES");
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                     clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_addr;

`ifdef RAM_CLEAR_EN
    // ------------------------------------------------------------------
    // Clear sweep: reset parks the FSM in CLEAR at address 0; one word is
    // zeroed per cycle once reset is released, and the FSM drops to IDLE
    // after the last address has been written.
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_addr_q, clr_addr_d;

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDRESS_WIDTH'(1);
                if (clr_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    // No sweep write on a reset edge: the sweep starts at the first
    // non-reset edge so that address 0 is the first word cleared.
    assign clr_we   = busy && !rst;
    assign clr_addr = clr_addr_q;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // ------------------------------------------------------------------
    // Port qualification. A write on a reset edge is dropped; the read
    // pipeline is cleared by reset anyway.
    // ------------------------------------------------------------------
    logic wr_accept;
    logic rd_accept;

    assign wr_accept = wr_en && !busy && !rst;
    assign rd_accept = rd_en && !busy;

    // ------------------------------------------------------------------
    // Array write: sweep and user writes are mutually exclusive because
    // the user port is blocked while busy.
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch; resetting a memory would turn
    // it into flops and prevent RAM inference.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i*LW +: LW] <= din[i*LW +: LW];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-first merge: on a same-address collision, masked lanes come
    // from din and unmasked lanes from the stored word.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fwd_word;

    always_comb begin
        fwd_word = mem[rd_addr];
        if (wr_accept && (wr_addr == rd_addr)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    fwd_word[i*LW +: LW] = din[i*LW +: LW];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. dout only loads when a valid word arrives, so it
    // holds the last returned value between reads.
    // ------------------------------------------------------------------
    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                dout     <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_accept;
                if (rd_accept) begin
                    dout <= fwd_word;
                end
            end
        end
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] data_s1;
        logic                  valid_s1;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_s1  <= '0;
                valid_s1 <= 1'b0;
                dout     <= '0;
                rd_valid <= 1'b0;
            end else begin
                valid_s1 <= rd_accept;
                if (rd_accept) begin
                    data_s1 <= fwd_word;
                end
                rd_valid <= valid_s1;
                if (valid_s1) begin
                    dout <= data_s1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_pipe.sv
// -----------------------------------------------------------------------------
// tb_ram_dp_pipe
//   Directed bench for ram_dp_pipe. Two instances share one stimulus:
//   u_l1 with READ_LATENCY=1 and u_l2 with READ_LATENCY=2 (both
//   ADDRESS_WIDTH=4, DATA_WIDTH=16, LANES=2). Expected values are written
//   out by hand. With RAM_CLEAR_EN defined the clear sweep is also checked.
// -----------------------------------------------------------------------------
module tb_ram_dp_pipe;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LN = 2;

`ifdef RAM_CLEAR_EN
    // A reset restarts the sweep, so words written before it read back as 0.
    localparam logic [15:0] EXP_KEEP3 = 16'h0000;
    localparam logic [15:0] EXP_KEEP2 = 16'h0000;
`else
    localparam logic [15:0] EXP_KEEP3 = 16'hAB34;
    localparam logic [15:0] EXP_KEEP2 = 16'h3002;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [LN-1:0] wr_mask;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] dout1, dout2;
    logic          rv1, rv2;
    logic          busy1, busy2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_dp_pipe #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .READ_LATENCY(1)
    ) u_l1 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .dout(dout1), .rd_valid(rv1), .busy(busy1)
    );

    ram_dp_pipe #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .READ_LATENCY(2)
    ) u_l2 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .dout(dout2), .rd_valid(rv2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [AW-1:0] a,
                          input logic [LN-1:0] m, input logic [DW-1:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_mask = m;
        din     = d;
    endtask

    task automatic set_rd(input logic en, input logic [AW-1:0] a);
        rd_en   = en;
        rd_addr = a;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy1 || busy2) && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy1 | busy2}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] exp_d1 [6];
        logic [15:0] exp_d2 [6];
        logic        exp_v1 [6];
        logic        exp_v2 [6];

        rst = 1'b1;
        set_wr(1'b0, '0, '0, '0);
        set_rd(1'b0, '0);
        tick();
        tick();

        // Reset state
        check("rst_dout1", dout1, 0);
        check("rst_rv1",   rv1,   0);
        check("rst_dout2", dout2, 0);
        check("rst_rv2",   rv2,   0);
        rst = 1'b0;
        wait_idle("idle_after_rst");
`ifndef RAM_CLEAR_EN
        check("busy_tied_low", {busy1, busy2}, 0);
`endif

        // 1. full write then read
        set_wr(1'b1, 4'd3, 2'b11, 16'hABCD);
        tick();
        set_wr(1'b0, '0, '0, '0);
        set_rd(1'b1, 4'd3);
        tick();
        check("t1_rv1",    rv1,   1);
        check("t1_dout1",  dout1, 16'hABCD);
        check("t1_rv2_early", rv2, 0);
        set_rd(1'b0, '0);
        tick();
        check("t1_rv1_pulse", rv1, 0);
        check("t1_dout1_hold", dout1, 16'hABCD);
        check("t1_rv2",    rv2,   1);
        check("t1_dout2",  dout2, 16'hABCD);
        tick();
        check("t1_rv2_pulse", rv2, 0);

        // 2. lower lane only
        set_wr(1'b1, 4'd3, 2'b01, 16'h1234);
        tick();
        set_wr(1'b0, '0, '0, '0);
        set_rd(1'b1, 4'd3);
        tick();
        check("t2_dout1", dout1, 16'hAB34);
        set_rd(1'b0, '0);
        tick();
        check("t2_dout2", dout2, 16'hAB34);

        // 3a. same-edge write/read, full mask
        set_wr(1'b1, 4'd5, 2'b11, 16'h5555);
        set_rd(1'b1, 4'd5);
        tick();
        check("t3a_rv1",   rv1,   1);
        check("t3a_dout1", dout1, 16'h5555);
        set_rd(1'b0, '0);
        set_wr(1'b1, 4'd6, 2'b11, 16'h0000);
        tick();
        check("t3a_dout2", dout2, 16'h5555);
        check("t3a_rv1_off", rv1, 0);

        // 3b. same-edge write/read, upper lane only over 0x0000
        set_wr(1'b1, 4'd6, 2'b10, 16'h5555);
        set_rd(1'b1, 4'd6);
        tick();
        check("t3b_dout1", dout1, 16'h5500);
        set_wr(1'b0, '0, '0, '0);
        set_rd(1'b0, '0);
        tick();
        check("t3b_dout2", dout2, 16'h5500);

        // 3c. different addresses on the same edge are independent
        set_wr(1'b1, 4'd8, 2'b11, 16'h1111);
        set_rd(1'b1, 4'd5);
        tick();
        check("t3c_dout1", dout1, 16'h5555);
        set_wr(1'b0, '0, '0, '0);
        set_rd(1'b1, 4'd8);
        tick();
        check("t3c_wr8_dout1", dout1, 16'h1111);
        check("t3c_dout2",     dout2, 16'h5555);
        set_rd(1'b0, '0);
        tick();
        check("t3c_wr8_dout2", dout2, 16'h1111);

        // 4. back-to-back reads @0..3
        set_wr(1'b1, 4'd0, 2'b11, 16'h1000);
        tick();
        set_wr(1'b1, 4'd1, 2'b11, 16'h2001);
        tick();
        set_wr(1'b1, 4'd2, 2'b11, 16'h3002);
        tick();
        set_wr(1'b0, '0, '0, '0);

        exp_v1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_d1 = '{16'h1000, 16'h2001, 16'h3002, 16'hAB34, 16'hAB34, 16'hAB34};
        exp_v2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d2 = '{16'h1111, 16'h1000, 16'h2001, 16'h3002, 16'hAB34, 16'hAB34};
        for (int i = 0; i < 6; i++) begin
            set_rd(i < 4, AW'(i));
            tick();
            check($sformatf("t4_rv1_%0d", i),   rv1,   exp_v1[i]);
            check($sformatf("t4_dout1_%0d", i), dout1, exp_d1[i]);
            check($sformatf("t4_rv2_%0d", i),   rv2,   exp_v2[i]);
            check($sformatf("t4_dout2_%0d", i), dout2, exp_d2[i]);
        end
        set_rd(1'b0, '0);

        // 5. reset one cycle after a read; a write on the reset edge is dropped
        set_rd(1'b1, 4'd1);
        tick();
        set_rd(1'b0, '0);
        set_wr(1'b1, 4'd2, 2'b11, 16'hFFFF);
        rst = 1'b1;
        tick();
        set_wr(1'b0, '0, '0, '0);
        check("t5_rv2",   rv2,   0);
        check("t5_dout2", dout2, 0);
        check("t5_dout1", dout1, 0);
        rst = 1'b0;
        tick();
        check("t5_rv2_after", rv2, 0);
        wait_idle("idle_after_t5");
        set_rd(1'b1, 4'd3);
        tick();
        check("t5_keep3_dout1", dout1, EXP_KEEP3);
        set_rd(1'b1, 4'd2);
        tick();
        check("t5_keep3_dout2", dout2, EXP_KEEP3);
        check("t5_keep2_dout1", dout1, EXP_KEEP2);
        set_rd(1'b0, '0);
        tick();
        check("t5_keep2_dout2", dout2, EXP_KEEP2);

`ifdef RAM_CLEAR_EN
        // 6. clear sweep length, ignored write/read while busy, all-zero array
        begin
            int cnt = 0;
            logic saw_valid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            set_wr(1'b1, 4'd7, 2'b11, 16'hFFFF);
            set_rd(1'b1, 4'd7);
            while (busy1 && cnt < 100) begin
                tick();
                cnt++;
                saw_valid = saw_valid | rv1 | rv2;
            end
            set_wr(1'b0, '0, '0, '0);
            set_rd(1'b0, '0);
            check("t6_busy_cycles", cnt, 16);
            check("t6_no_valid",    saw_valid, 0);
            for (int i = 0; i < 16; i++) begin
                set_rd(1'b1, AW'(i));
                tick();
                check($sformatf("t6_clr_rv_%0d", i),   rv1,   1);
                check($sformatf("t6_clr_dout_%0d", i), dout1, 16'h0000);
            end
            set_rd(1'b0, '0);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
